// File: rtl/cdb_arbiter.sv
// cdb_arbiter: writeback-side producer of the common data bus.
//
// Each functional unit pushes completed results (tag + value) into its own
// small FIFO. Every cycle the non-empty FIFOs are scanned round-robin from
// rr_ptr. Up to CDB_W heads are granted, and they are loaded into registered
// broadcast lanes that fill contiguously from lane 0.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      synchronous active-low reset
//   flush      synchronous flush, drops all buffered results
//   fu_valid   per-source result valid
//   fu_tag     per-source destination tag
//   fu_val     per-source result value
//   fu_ready   per-source accept (FIFO not full, not in reset/flush)
//   cdb_valid  registered lane valid
//   cdb_tag    registered lane tag (0 on unused lanes)
//   cdb_val    registered lane value (0 on unused lanes)

package config_pkg;
  typedef struct packed {
    int unsigned ILEN;
  } cfg_t;

  localparam cfg_t EmptyCfg = '{ILEN: 32};
endpackage

module cdb_arbiter #(
  parameter config_pkg::cfg_t Cfg = config_pkg::EmptyCfg,
  parameter int N_SRC      = 6,
  parameter int CDB_W      = 4,
  parameter int DATA_W     = int'(Cfg.ILEN),
  parameter int TAG_W      = 6,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [N_SRC-1:0]  fu_valid,
  input  logic [TAG_W-1:0]  fu_tag  [0:N_SRC-1],
  input  logic [DATA_W-1:0] fu_val  [0:N_SRC-1],
  output logic [N_SRC-1:0]  fu_ready,
  output logic [CDB_W-1:0]  cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag [0:CDB_W-1],
  output logic [DATA_W-1:0] cdb_val [0:CDB_W-1]
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int LN_W  = (CDB_W > 1) ? $clog2(CDB_W) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [RR_W:0]    N_SRC_L  = (RR_W + 1)'(N_SRC);
  localparam logic [RR_W-1:0]  SRC_LAST = RR_W'(N_SRC - 1);
  localparam logic [RR_W-1:0]  RR_ONE   = RR_W'(1);
  localparam logic [LN_W:0]    CDB_W_L  = (LN_W + 1)'(CDB_W);
  localparam logic [LN_W:0]    LN_ONE   = (LN_W + 1)'(1);

  logic [TAG_W-1:0]  mem_tag [N_SRC][FIFO_DEPTH];
  logic [DATA_W-1:0] mem_val [N_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]  head    [N_SRC];
  logic [PTR_W-1:0]  tail    [N_SRC];
  logic [CNT_W-1:0]  count   [N_SRC];

  logic [RR_W-1:0]   rr_ptr;
  logic [RR_W-1:0]   rr_next;
  logic [N_SRC-1:0]  push;
  logic [N_SRC-1:0]  pop;
  logic [CDB_W-1:0]  lane_valid;
  logic [TAG_W-1:0]  lane_tag [CDB_W];
  logic [DATA_W-1:0] lane_val [CDB_W];
  logic [RR_W:0]     scan;
  logic [RR_W-1:0]   src;
  logic [LN_W:0]     n_grant;

  // Ready looks only at the current count, so a full FIFO refuses input
  // even in a cycle where its head is being broadcast.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      fu_ready[i] = rst_n & ~flush & (count[i] < CNT_FULL);
    end
  end

  assign push = fu_valid & fu_ready;

  // Circular scan from rr_ptr; the k-th non-empty source found lands on
  // lane k until the lanes run out.
  always_comb begin
    pop        = '0;
    lane_valid = '0;
    rr_next    = rr_ptr;
    n_grant    = '0;
    scan       = '0;
    src        = '0;
    for (int l = 0; l < CDB_W; l++) begin
      lane_tag[l] = '0;
      lane_val[l] = '0;
    end
    for (int k = 0; k < N_SRC; k++) begin
      scan = {1'b0, rr_ptr} + (RR_W + 1)'(k);
      if (scan >= N_SRC_L) begin
        scan = scan - N_SRC_L;
      end
      src = scan[RR_W-1:0];
      if ((count[src] != '0) && (n_grant < CDB_W_L)) begin
        pop[src]                        = 1'b1;
        lane_valid[n_grant[LN_W-1:0]]   = 1'b1;
        lane_tag[n_grant[LN_W-1:0]]     = mem_tag[src][head[src]];
        lane_val[n_grant[LN_W-1:0]]     = mem_val[src][head[src]];
        rr_next                         = (src == SRC_LAST) ? '0 : src + RR_ONE;
        n_grant                         = n_grant + LN_ONE;
      end
    end
  end

  // Storage needs no reset: push is held low during reset and flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        mem_tag[i][tail[i]] <= fu_tag[i];
        mem_val[i][tail[i]] <= fu_val[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      for (int l = 0; l < CDB_W; l++) begin
        cdb_tag[l] <= '0;
        cdb_val[l] <= '0;
      end
      for (int i = 0; i < N_SRC; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      rr_ptr    <= rr_next;
      cdb_valid <= lane_valid;
      for (int l = 0; l < CDB_W; l++) begin
        cdb_tag[l] <= lane_tag[l];
        cdb_val[l] <= lane_val[l];
      end
      for (int i = 0; i < N_SRC; i++) begin
        if (push[i]) begin
          tail[i] <= (tail[i] == PTR_LAST) ? '0 : tail[i] + PTR_ONE;
        end
        if (pop[i]) begin
          head[i] <= (head[i] == PTR_LAST) ? '0 : head[i] + PTR_ONE;
        end
        if (push[i] && !pop[i]) begin
          count[i] <= count[i] + CNT_ONE;
        end else if (!push[i] && pop[i]) begin
          count[i] <= count[i] - CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed vectors plus a per-source scoreboard
// that tracks accepted results, predicts fu_ready and checks each broadcast.
module tb_cdb_arbiter;

  localparam int N_SRC  = 6;
  localparam int CDB_W  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic [N_SRC-1:0]  fu_valid = '0;
  logic [TAG_W-1:0]  fu_tag  [0:N_SRC-1];
  logic [DATA_W-1:0] fu_val  [0:N_SRC-1];
  logic [N_SRC-1:0]  fu_ready;
  logic [CDB_W-1:0]  cdb_valid;
  logic [TAG_W-1:0]  cdb_tag [0:CDB_W-1];
  logic [DATA_W-1:0] cdb_val [0:CDB_W-1];

  cdb_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .fu_val    (fu_val),
    .fu_ready  (fu_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_val   (cdb_val)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] val;
  } ent_t;

  ent_t             sbq [N_SRC][$];
  int               wait_cnt [N_SRC];
  logic [N_SRC-1:0] pend = '0;
  bit               saw_full = 1'b0;

  always @(negedge clk) begin
    logic [N_SRC-1:0] granted;
    logic [N_SRC-1:0] exp_ready;
    bit               found;
    bit               lanes_ok;
    ent_t             e;
    granted  = '0;
    lanes_ok = 1'b1;
    for (int l = 0; l < CDB_W; l++) begin
      if (cdb_valid[l]) begin
        found = 1'b0;
        for (int j = 0; j < N_SRC; j++) begin
          if (!found && !granted[j] && sbq[j].size() > 0 &&
              sbq[j][0].tag == cdb_tag[l] && sbq[j][0].val == cdb_val[l]) begin
            found      = 1'b1;
            granted[j] = 1'b1;
            void'(sbq[j].pop_front());
          end
        end
        total++;
        if (!found) begin
          bad++;
          $display("FAIL sb_lane%0d actual tag=%0d val=%h required=a pending head in order",
                   l, cdb_tag[l], cdb_val[l]);
        end
      end else if (cdb_tag[l] != '0 || cdb_val[l] != '0) begin
        lanes_ok = 1'b0;
      end
      if (l > 0 && cdb_valid[l] && !cdb_valid[l-1]) lanes_ok = 1'b0;
    end
    chk("sb_lane_shape", lanes_ok, 1'b1);

    for (int j = 0; j < N_SRC; j++) begin
      if (pend[j]) begin
        wait_cnt[j] = granted[j] ? 0 : wait_cnt[j] + 1;
        total++;
        if (wait_cnt[j] > 1) begin
          bad++;
          $display("FAIL sb_starve src%0d actual_wait=%0d required<=1", j, wait_cnt[j]);
        end
      end else begin
        wait_cnt[j] = 0;
      end
    end

    for (int j = 0; j < N_SRC; j++) begin
      exp_ready[j] = rst_n && !flush && (sbq[j].size() < 2);
      if (rst_n && !flush && !exp_ready[j]) saw_full = 1'b1;
      pend[j] = (sbq[j].size() > 0);
    end
    chk("sb_ready", fu_ready, exp_ready);

    for (int j = 0; j < N_SRC; j++) begin
      if (fu_valid[j] && exp_ready[j]) begin
        e.tag = fu_tag[j];
        e.val = fu_val[j];
        sbq[j].push_back(e);
      end
    end

    if (!rst_n || flush) begin
      for (int j = 0; j < N_SRC; j++) begin
        sbq[j].delete();
        wait_cnt[j] = 0;
      end
      pend = '0;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [2:0] seq [N_SRC];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_seq(input logic [N_SRC-1:0] mask);
    for (int i = 0; i < N_SRC; i++) begin
      fu_valid[i] = mask[i];
      if (mask[i]) begin
        fu_tag[i] = {3'(i), seq[i]};
        fu_val[i] = {16'hC0DE, 8'(i), 2'b00, fu_tag[i]};
        seq[i]    = seq[i] + 3'd1;
      end
    end
  endtask

  task automatic drive_tab(input logic [N_SRC-1:0] mask, input int base);
    for (int i = 0; i < N_SRC; i++) begin
      fu_valid[i] = mask[i];
      fu_tag[i]   = 6'(base + i);
      fu_val[i]   = 32'hA5A5_0000 | 32'(base + i);
    end
  endtask

  function automatic logic [CDB_W-1:0][TAG_W-1:0] lane_tags();
    logic [CDB_W-1:0][TAG_W-1:0] t;
    for (int l = 0; l < CDB_W; l++) t[l] = cdb_tag[l];
    return t;
  endfunction

  typedef struct packed {
    logic [N_SRC-1:0]            mask;
    logic [CDB_W-1:0]            v2;
    logic [CDB_W-1:0][TAG_W-1:0] t2;
    logic [CDB_W-1:0]            v3;
    logic [CDB_W-1:0][TAG_W-1:0] t3;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int qleft;
    // Tags are 10 + source index; rr_ptr is 0 at the start of each vector.
    vecs[0] = '{mask: 6'b000100, v2: 4'b0001, t2: {6'd0, 6'd0, 6'd0, 6'd12},
                v3: 4'b0000, t3: '0};
    vecs[1] = '{mask: 6'b111111, v2: 4'b1111, t2: {6'd13, 6'd12, 6'd11, 6'd10},
                v3: 4'b0011, t3: {6'd0, 6'd0, 6'd15, 6'd14}};
    vecs[2] = '{mask: 6'b101010, v2: 4'b0111, t2: {6'd0, 6'd15, 6'd13, 6'd11},
                v3: 4'b0000, t3: '0};
    vecs[3] = '{mask: 6'b110011, v2: 4'b1111, t2: {6'd15, 6'd14, 6'd11, 6'd10},
                v3: 4'b0000, t3: '0};
    vecs[4] = '{mask: 6'b111110, v2: 4'b1111, t2: {6'd14, 6'd13, 6'd12, 6'd11},
                v3: 4'b0001, t3: {6'd0, 6'd0, 6'd0, 6'd15}};

    for (int i = 0; i < N_SRC; i++) begin
      fu_tag[i] = '0;
      fu_val[i] = '0;
      seq[i]    = '0;
    end

    // Reset held two cycles with every source requesting.
    rst_n    = 1'b0;
    fu_valid = '1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", fu_ready, 6'h00);
      chk("rst_cdb_valid", cdb_valid, 4'h0);
      chk("rst_cdb_tag0", cdb_tag[0], 6'd0);
    end
    tick();
    rst_n    = 1'b1;
    fu_valid = '0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_ready", fu_ready, 6'h3f);
      chk("post_rst_cdb_valid", cdb_valid, 4'h0);
      tick();
    end

    // Single result: source 2, minimum latency c -> c+2.
    fu_valid  = 6'b000100;
    fu_tag[2] = 6'd5;
    fu_val[2] = 32'hDEADBEEF;
    tick();
    fu_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("single_c2_valid", cdb_valid, 4'b0001);
    chk("single_c2_tag", cdb_tag[0], 6'd5);
    chk("single_c2_val", cdb_val[0], 32'hDEADBEEF);
    @(negedge clk);
    chk("single_c3_valid", cdb_valid, 4'b0000);

    // Table-driven bursts, each from a flushed state.
    for (int v = 0; v < 5; v++) begin
      tick();
      flush    = 1'b1;
      fu_valid = '0;
      tick();
      flush = 1'b0;
      drive_tab(vecs[v].mask, 10);
      tick();
      fu_valid = '0;
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_c2_valid", v), cdb_valid, vecs[v].v2);
      chk($sformatf("vec%0d_c2_tags", v), lane_tags(), vecs[v].t2);
      @(negedge clk);
      chk($sformatf("vec%0d_c3_valid", v), cdb_valid, vecs[v].v3);
      chk($sformatf("vec%0d_c3_tags", v), lane_tags(), vecs[v].t3);
    end

    // Round-robin pointer carries over: after granting 0,1 the scan starts at 2.
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_tab(6'b000011, 10);
    tick();
    fu_valid = '0;
    tick();
    drive_tab(6'b111111, 20);
    @(negedge clk);
    chk("rr_a_valid", cdb_valid, 4'b0011);
    chk("rr_a_tags", lane_tags(), {6'd0, 6'd0, 6'd11, 6'd10});
    tick();
    fu_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rr_b_valid", cdb_valid, 4'b1111);
    chk("rr_b_tags", lane_tags(), {6'd25, 6'd24, 6'd23, 6'd22});
    @(negedge clk);
    chk("rr_c_valid", cdb_valid, 4'b0011);
    chk("rr_c_tags", lane_tags(), {6'd0, 6'd0, 6'd21, 6'd20});

    // Full FIFO: put rr_ptr at 1, then fill source 0 to two entries.
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive_seq(6'b000001);
    tick();
    fu_valid = '0;
    repeat (3) tick();
    drive_seq(6'h3f);
    @(negedge clk);
    chk("full_a_ready", fu_ready, 6'h3f);
    tick();
    drive_seq(6'h3f);
    @(negedge clk);
    chk("full_b_ready", fu_ready, 6'h3f);
    tick();
    fu_valid = '0;
    @(negedge clk);
    chk("full_c_ready", fu_ready, 6'b011110);
    tick();
    @(negedge clk);
    chk("full_d_ready", fu_ready, 6'h3f);
    repeat (4) tick();

    // Sustained load on all sources.
    for (int t = 0; t < 20; t++) begin
      tick();
      drive_seq(6'h3f);
      @(negedge clk);
      if (t >= 2) chk($sformatf("sustain_t%0d_lanes", t), cdb_valid, 4'hf);
    end
    tick();
    fu_valid = '0;
    repeat (6) tick();
    chk("sustain_saw_full", saw_full, 1'b1);

    // Flush with results buffered and a new result offered in the flush cycle.
    drive_seq(6'h1f);
    tick();
    drive_seq(6'h1f);
    tick();
    flush = 1'b1;
    drive_seq(6'b000010);
    @(negedge clk);
    chk("flush_f_ready", fu_ready, 6'h00);
    tick();
    flush    = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    chk("flush_f1_valid", cdb_valid, 4'h0);
    chk("flush_f1_ready", fu_ready, 6'h3f);
    tick();
    @(negedge clk);
    chk("flush_f2_valid", cdb_valid, 4'h0);

    // Reset and flush together, then confirm rr_ptr restarted at source 0.
    tick();
    drive_seq(6'h3f);
    tick();
    rst_n = 1'b0;
    flush = 1'b1;
    drive_seq(6'h3f);
    @(negedge clk);
    chk("rstflush_ready", fu_ready, 6'h00);
    tick();
    rst_n    = 1'b1;
    flush    = 1'b0;
    fu_valid = '0;
    @(negedge clk);
    chk("rstflush_valid", cdb_valid, 4'h0);
    chk("rstflush_ready_after", fu_ready, 6'h3f);
    tick();
    drive_seq(6'h3f);
    tick();
    fu_valid = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rstflush_rr_src", cdb_tag[0][5:3], 3'd0);
    repeat (5) tick();

    @(negedge clk);
    qleft = 0;
    for (int j = 0; j < N_SRC; j++) qleft += sbq[j].size();
    chk("sb_drained", qleft, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
